// File: rtl/clock_phases_pkg.sv
// Memory-arbiter phase codes shared by the video output and the memory manager.
package clock_phases_pkg;

  // One pixel slot: Idle -> VideoRead -> {MemWrite | MemRead | Nop} -> Complete.
  typedef enum logic [2:0] {
    PhaseIdle      = 3'd0,
    PhaseVideoRead = 3'd1,
    PhaseMemWrite  = 3'd2,
    PhaseMemRead   = 3'd3,
    PhaseNop       = 3'd4,
    PhaseComplete  = 3'd5
  } clock_phase_e;

endpackage

// File: rtl/video_timing_pkg.sv
// 640x480 display timing shared by the video path.
package video_timing_pkg;

  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_FRONT   = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BACK    = 48;
  localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_FRONT   = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BACK    = 33;
  localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // Inclusive sync windows in counter coordinates.
  localparam int unsigned H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int unsigned V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  typedef logic [9:0] count_t;

endpackage

// File: rtl/video_timing.sv
// Horizontal/vertical raster counters with visible-region and sync-window decode.
module video_timing
  import video_timing_pkg::*;
(
  input  logic   clock,
  input  logic   reset,
  input  logic   advance,
  output count_t h_count,
  output count_t v_count,
  output logic   visible,
  output logic   h_sync_active,
  output logic   v_sync_active
);

  count_t h_count_q, h_count_d;
  count_t v_count_q, v_count_d;
  logic   h_last, v_last;

  // Next raster position: step right, wrap to the next line, wrap to the top of frame.
  always_comb begin
    h_last    = (h_count_q == count_t'(H_TOTAL - 1));
    v_last    = (v_count_q == count_t'(V_TOTAL - 1));
    h_count_d = h_count_q;
    v_count_d = v_count_q;
    if (advance) begin
      if (h_last) begin
        h_count_d = '0;
        v_count_d = v_last ? '0 : v_count_q + 1'b1;
      end else begin
        h_count_d = h_count_q + 1'b1;
      end
    end
  end

  // Counters only move on slot-complete edges.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      h_count_q <= '0;
      v_count_q <= '0;
    end else if (advance) begin
      h_count_q <= h_count_d;
      v_count_q <= v_count_d;
    end
  end

  // Region and sync-window decode of the current position.
  always_comb begin
    visible       = (h_count_q < count_t'(H_VISIBLE)) && (v_count_q < count_t'(V_VISIBLE));
    h_sync_active = (h_count_q >= count_t'(H_SYNC_START)) && (h_count_q <= count_t'(H_SYNC_END));
    v_sync_active = (v_count_q >= count_t'(V_SYNC_START)) && (v_count_q <= count_t'(V_SYNC_END));
  end

  assign h_count = h_count_q;
  assign v_count = v_count_q;

endmodule

// File: rtl/video_output.sv
// Framebuffer fetch address generation and registered pixel/sync output for a 640x480 display.
module video_output
  import clock_phases_pkg::*;
  import video_timing_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  currentState,
  output logic [16:0] videoAddress,
  input  logic [7:0]  videoData,
  input  logic        videoDataReady,
  output logic [7:0]  videoOutput,
  output logic        hSync,
  output logic        vSync
);

  count_t     h_count, v_count;
  logic       visible, h_sync_active, v_sync_active;
  logic       advance;
  logic [7:0] pixel_q, pixel_d;
  logic       h_sync_q, v_sync_q;

  // Codes 6..7 are simply not Complete, so they never advance the raster.
  assign advance = (currentState == PhaseComplete);

  video_timing u_timing (
    .clock         (clock),
    .reset         (reset),
    .advance       (advance),
    .h_count       (h_count),
    .v_count       (v_count),
    .visible       (visible),
    .h_sync_active (h_sync_active),
    .v_sync_active (v_sync_active)
  );

  // Address depends only on the counters so it is stable across the whole slot;
  // each source pixel covers a 2x2 block of display pixels.
  always_comb begin
    videoAddress = '0;
    pixel_d      = 8'h00;
    if (visible) begin
      videoAddress = {v_count[8:1], h_count[9:1]};
      pixel_d      = videoData;
    end
  end

  // Pixel byte loads on any ready strobe; blanking forces black.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pixel_q <= 8'h00;
    end else if (videoDataReady) begin
      pixel_q <= pixel_d;
    end
  end

  // Active-low syncs are registered on the same edge that advances the counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      h_sync_q <= 1'b1;
      v_sync_q <= 1'b1;
    end else if (advance) begin
      h_sync_q <= ~h_sync_active;
      v_sync_q <= ~v_sync_active;
    end
  end

  assign videoOutput = pixel_q;
  assign hSync       = h_sync_q;
  assign vSync       = v_sync_q;

  // Bits that do not take part in the 2x2 address mapping.
  logic unused_count_bits;
  assign unused_count_bits = ^{v_count[9], v_count[0], h_count[0]};

endmodule

// File: tb/tb_video_output.sv
// Directed self-checking bench for video_output.
module tb_video_output;

  logic        clock;
  logic        reset;
  logic [2:0]  currentState;
  logic [16:0] videoAddress;
  logic [7:0]  videoData;
  logic        videoDataReady;
  logic [7:0]  videoOutput;
  logic        hSync;
  logic        vSync;

  int n_cmp = 0;
  int n_bad = 0;
  int th = 0;
  int tv = 0;

  video_output dut (
    .clock          (clock),
    .reset          (reset),
    .currentState   (currentState),
    .videoAddress   (videoAddress),
    .videoData      (videoData),
    .videoDataReady (videoDataReady),
    .videoOutput    (videoOutput),
    .hSync          (hSync),
    .vSync          (vSync)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic model_advance();
    if (th == 799) begin
      th = 0;
      tv = (tv == 524) ? 0 : tv + 1;
    end else begin
      th = th + 1;
    end
  endtask

  // One clock with the given phase; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic [2:0] st, input logic rdy, input logic [7:0] d);
    currentState   = st;
    videoDataReady = rdy;
    videoData      = d;
    @(posedge clock);
    #1;
    if (st == 3'd5) model_advance();
  endtask

  task automatic run_slot(input logic [7:0] d);
    step(3'd0, 1'b0, d);
    step(3'd1, 1'b0, d);
    step(3'd4, 1'b0, d);
    step(3'd5, 1'b1, d);
  endtask

  task automatic fast(input logic [7:0] d);
    step(3'd5, 1'b1, d);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    currentState = 3'd0; videoDataReady = 1'b0; videoData = 8'hA5;
    repeat (2) @(posedge clock);
    #1;
    n_cmp++; if (videoAddress !== 17'h0) begin n_bad++;
      $display("FAIL reset_addr got %h want %h", videoAddress, 17'h0); end
    n_cmp++; if (videoOutput !== 8'h00) begin n_bad++;
      $display("FAIL reset_pix got %h want %h", videoOutput, 8'h00); end
    n_cmp++; if (hSync !== 1'b1) begin n_bad++;
      $display("FAIL reset_hsync got %b want 1", hSync); end
    n_cmp++; if (vSync !== 1'b1) begin n_bad++;
      $display("FAIL reset_vsync got %b want 1", vSync); end
    reset = 1'b1;
    th = 0; tv = 0;
  endtask

  task automatic test_first_slot();
    n_cmp++; if (videoAddress !== 17'h0) begin n_bad++;
      $display("FAIL first_addr got %h want %h", videoAddress, 17'h0); end
    step(3'd0, 1'b0, 8'hA5);
    n_cmp++; if (videoOutput !== 8'h00) begin n_bad++;
      $display("FAIL first_pix_early got %h want %h", videoOutput, 8'h00); end
    step(3'd1, 1'b0, 8'hA5);
    step(3'd4, 1'b0, 8'hA5);
    step(3'd5, 1'b1, 8'hA5);
    n_cmp++; if (videoOutput !== 8'hA5) begin n_bad++;
      $display("FAIL first_pix got %h want %h", videoOutput, 8'hA5); end
    n_cmp++; if (hSync !== 1'b1 || vSync !== 1'b1) begin n_bad++;
      $display("FAIL first_sync got %b%b want 11", hSync, vSync); end
    n_cmp++; if (videoAddress !== 17'h0) begin n_bad++;
      $display("FAIL slot1_addr got %h want %h", videoAddress, 17'h0); end
  endtask

  task automatic test_address();
    run_slot(8'hA5);
    n_cmp++; if (videoAddress !== 17'h00001) begin n_bad++;
      $display("FAIL addr_h2 got %h want %h", videoAddress, 17'h00001); end
    for (int i = 0; i < 700 && th != 639; i++) run_slot(8'hA5);
    n_cmp++; if (videoAddress !== 17'h0013F) begin n_bad++;
      $display("FAIL addr_h639 got %h want %h", videoAddress, 17'h0013F); end
    run_slot(8'h3C);
    n_cmp++; if (videoOutput !== 8'h3C) begin n_bad++;
      $display("FAIL pix_h639 got %h want %h", videoOutput, 8'h3C); end
    n_cmp++; if (videoAddress !== 17'h0) begin n_bad++;
      $display("FAIL addr_h640 got %h want %h", videoAddress, 17'h0); end
  endtask

  task automatic test_hsync();
    int lows = 0;
    int first = -1;
    int pix_bad = 0;
    for (int i = 0; i < 16; i++) run_slot(8'hFF);
    n_cmp++; if (videoOutput !== 8'h00) begin n_bad++;
      $display("FAIL blank_pix got %h want %h", videoOutput, 8'h00); end
    n_cmp++; if (hSync !== 1'b1) begin n_bad++;
      $display("FAIL hsync_pre got %b want 1", hSync); end
    for (int i = 0; i < 100; i++) begin
      run_slot(8'hFF);
      if (hSync === 1'b0) begin
        lows++;
        if (first < 0) first = i;
      end
      if (videoOutput !== 8'h00) pix_bad++;
    end
    n_cmp++; if (lows != 96) begin n_bad++;
      $display("FAIL hsync_width got %0d want 96", lows); end
    n_cmp++; if (first != 0) begin n_bad++;
      $display("FAIL hsync_start got %0d want 0", first); end
    n_cmp++; if (pix_bad != 0) begin n_bad++;
      $display("FAIL hblank_pix got %0d nonzero want 0", pix_bad); end
    n_cmp++; if (hSync !== 1'b1) begin n_bad++;
      $display("FAIL hsync_post got %b want 1", hSync); end
  endtask

  task automatic test_line2();
    for (int i = 0; i < 100 && th != 0; i++) run_slot(8'h00);
    for (int i = 0; i < 800; i++) run_slot(8'h00);
    n_cmp++; if (videoAddress !== 17'h00200) begin n_bad++;
      $display("FAIL addr_line2 got %h want %h", videoAddress, 17'h00200); end
    run_slot(8'h11);
    n_cmp++; if (videoOutput !== 8'h11) begin n_bad++;
      $display("FAIL pix_line2 got %h want %h", videoOutput, 8'h11); end
  endtask

  task automatic test_freeze();
    for (int i = 0; i < 100; i++) step(3'd4, 1'b0, 8'hEE);
    n_cmp++; if (videoAddress !== 17'h00200) begin n_bad++;
      $display("FAIL freeze_addr got %h want %h", videoAddress, 17'h00200); end
    n_cmp++; if (videoOutput !== 8'h11) begin n_bad++;
      $display("FAIL freeze_pix got %h want %h", videoOutput, 8'h11); end
    n_cmp++; if (hSync !== 1'b1 || vSync !== 1'b1) begin n_bad++;
      $display("FAIL freeze_sync got %b%b want 11", hSync, vSync); end
    for (int i = 0; i < 4; i++) step(3'd6 + 3'(i & 1), 1'b0, 8'hEE);
    n_cmp++; if (videoAddress !== 17'h00200) begin n_bad++;
      $display("FAIL code67_addr got %h want %h", videoAddress, 17'h00200); end
    step(3'd4, 1'b1, 8'h66);
    n_cmp++; if (videoOutput !== 8'h66) begin n_bad++;
      $display("FAIL ready_nop_pix got %h want %h", videoOutput, 8'h66); end
    n_cmp++; if (videoAddress !== 17'h00200) begin n_bad++;
      $display("FAIL ready_nop_addr got %h want %h", videoAddress, 17'h00200); end
    run_slot(8'h22);
    n_cmp++; if (videoAddress !== 17'h00201 || videoOutput !== 8'h22) begin n_bad++;
      $display("FAIL after_freeze got %h/%h want %h/%h", videoAddress, videoOutput,
               17'h00201, 8'h22); end
  endtask

  task automatic test_vsync();
    int lows = 0;
    int pix_bad = 0;
    currentState = 3'd4; videoDataReady = 1'b0;
    force dut.u_timing.v_count_q = 10'd489;
    #1;
    release dut.u_timing.v_count_q;
    tv = 489;
    for (int i = 0; i < 800 && th != 0; i++) fast(8'hFF);
    n_cmp++; if (vSync !== 1'b1) begin n_bad++;
      $display("FAIL vsync_pre got %b want 1", vSync); end
    for (int i = 0; i < 1610; i++) begin
      fast(8'hFF);
      if (vSync === 1'b0) lows++;
      if (videoOutput !== 8'h00) pix_bad++;
    end
    n_cmp++; if (lows != 1600) begin n_bad++;
      $display("FAIL vsync_width got %0d want 1600", lows); end
    n_cmp++; if (pix_bad != 0) begin n_bad++;
      $display("FAIL vblank_pix got %0d nonzero want 0", pix_bad); end
    n_cmp++; if (vSync !== 1'b1 || videoAddress !== 17'h0) begin n_bad++;
      $display("FAIL vsync_post got %b/%h want 1/%h", vSync, videoAddress, 17'h0); end
  endtask

  task automatic test_wrap();
    currentState = 3'd4; videoDataReady = 1'b0;
    force dut.u_timing.v_count_q = 10'd524;
    #1;
    release dut.u_timing.v_count_q;
    tv = 524;
    for (int i = 0; i < 800 && th != 799; i++) fast(8'hFF);
    fast(8'hFF);
    n_cmp++; if (videoOutput !== 8'h00) begin n_bad++;
      $display("FAIL wrap_pix got %h want %h", videoOutput, 8'h00); end
    fast(8'h77);
    n_cmp++; if (videoOutput !== 8'h77) begin n_bad++;
      $display("FAIL wrap_origin_pix got %h want %h", videoOutput, 8'h77); end
    fast(8'h77);
    n_cmp++; if (videoAddress !== 17'h00001) begin n_bad++;
      $display("FAIL wrap_addr got %h want %h", videoAddress, 17'h00001); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 400 && th != 300; i++) fast(8'h5A);
    n_cmp++; if (videoAddress !== 17'h00096 || videoOutput !== 8'h5A) begin n_bad++;
      $display("FAIL mid_pre got %h/%h want %h/%h", videoAddress, videoOutput,
               17'h00096, 8'h5A); end
    #2;
    reset = 1'b0;
    #1;
    n_cmp++; if (videoAddress !== 17'h0 || videoOutput !== 8'h00) begin n_bad++;
      $display("FAIL mid_reset got %h/%h want %h/%h", videoAddress, videoOutput,
               17'h0, 8'h00); end
    n_cmp++; if (hSync !== 1'b1 || vSync !== 1'b1) begin n_bad++;
      $display("FAIL mid_reset_sync got %b%b want 11", hSync, vSync); end
    currentState = 3'd0; videoDataReady = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    th = 0; tv = 0;
    run_slot(8'h42);
    n_cmp++; if (videoOutput !== 8'h42 || videoAddress !== 17'h0) begin n_bad++;
      $display("FAIL post_reset got %h/%h want %h/%h", videoOutput, videoAddress,
               8'h42, 17'h0); end
    run_slot(8'h42);
    n_cmp++; if (videoAddress !== 17'h00001) begin n_bad++;
      $display("FAIL post_reset_addr got %h want %h", videoAddress, 17'h00001); end
  endtask

  initial begin
    test_reset();
    test_first_slot();
    test_address();
    test_hsync();
    test_line2();
    test_freeze();
    test_vsync();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/video_output.md
VIDEO_OUTPUT -- requirements
Module: video_output

Interface
REQ-001 H_VISIBLE, 640: active pixels per line.
REQ-002 H_FRONT / H_SYNC / H_BACK, 16 / 96 / 48: horizontal porch and sync widths in pixels (total 800).
REQ-003 V_VISIBLE, 480: active lines per frame.
REQ-004 V_FRONT / V_SYNC / V_BACK, 10 / 2 / 33: vertical porch and sync widths in lines (total 525).
REQ-005 clock  in  1  sole clock; all flops on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 currentState  in  3  memory-arbiter phase code from the shared clock-phase package.
REQ-008 videoAddress  out  17  framebuffer address of the pixel being fetched, {y[7:0], x[8:0]}.
REQ-009 videoData  in  8  framebuffer byte returned for videoAddress.
REQ-010 videoDataReady  in  1  one-cycle strobe; videoData valid while high.
REQ-011 videoOutput  out  8  pixel colour byte to the DAC.
REQ-012 hSync  out  1  horizontal sync, active-low.
REQ-013 vSync  out  1  vertical sync, active-low.

Function
REQ-014 Phase codes SHALL be IDLE=0, VIDEO_READ=1, MEM_WRITE=2, MEM_READ=3, NOP=4, COMPLETE=5. The arbiter cycles IDLE -> VIDEO_READ -> {MEM_WRITE|MEM_READ|NOP} -> COMPLETE, so one pixel slot is 4 clocks.
REQ-015 hCount (10 bit, 0..799) and vCount (10 bit, 0..524) SHALL advance only on a rising edge where currentState==COMPLETE.
REQ-016 On each advance, hCount SHALL increment.
REQ-017 When hCount is 799 at an advance, hCount SHALL wrap to 0 and vCount SHALL increment.
REQ-018 When hCount is 799 and vCount is 524 at an advance, vCount SHALL wrap to 0.
REQ-019 Visible region: hCount<640 and vCount<480.
REQ-020 videoAddress SHALL be {vCount[8:1], hCount[9:1]} when visible, else 0. It is derived from the counters only, so it is stable for the whole slot and meets the arbiter's falling-edge sample in IDLE. Each framebuffer pixel covers 2x2 display pixels (320x240 source).
REQ-021 On a rising edge with videoDataReady=1, videoOutput SHALL load videoData if the current counters are visible, else 8'h00. Otherwise videoOutput holds.
REQ-022 On the same COMPLETE edge, hSync SHALL be registered low iff 656<=hCount<=751.
REQ-023 On the same COMPLETE edge, vSync SHALL be registered low iff 490<=vCount<=491.
REQ-024 Colour and syncs therefore change together, once per slot, with one-slot latency from address to pixel.
REQ-025 videoDataReady asserted outside COMPLETE SHALL still load videoOutput (REQ-021) but SHALL NOT advance counters.
REQ-026 currentState values 6..7 SHALL be treated as non-COMPLETE (no advance).

Reset
REQ-027 While reset=0: hCount=0, vCount=0, videoOutput=8'h00, hSync=1, vSync=1, and videoAddress=0 as a consequence of the counter reset.
REQ-028 Assertion mid-frame SHALL clear state immediately, independent of clock.
REQ-029 After release, the first COMPLETE edge SHALL process pixel (0,0).

Structure
REQ-030 Phase codes (REQ-014) SHALL live in shared package clock_phases_pkg, used by both this block and the memory manager.
REQ-031 Timing parameters SHALL live in a shared package video_timing_pkg.
REQ-032 Counters, visible flag and sync decode SHALL form one sub-module, video_timing; video_output adds address mapping and pixel/sync registers.

Verification
REQ-033 Reset, then cycle phases 0,1,4,5 with videoData=8'hA5 and ready on COMPLETE -> first slot: videoAddress=0, then videoOutput=8'hA5, hSync=1, vSync=1.
REQ-034 Run 2 slots -> videoAddress stays 0 for slots 0-1, then 17'h00001 at hCount=2. Run through hCount=639 -> videoAddress=17'h0013F.
REQ-035 Advance to hCount=656 -> hSync low for exactly 96 slots (384 clocks); videoOutput=0 throughout blanking despite videoData=8'hFF.
REQ-036 Advance to line 2 -> videoAddress=17'h00200 at hCount=0. Run to vCount=490 -> vSync low for 2 lines (1600 slots).
REQ-037 Hold currentState at NOP for 100 cycles -> counters and outputs frozen. Next: at (799,524) a COMPLETE edge -> both counters wrap to 0.
REQ-038 Drop reset mid-line at hCount=300 -> all outputs at reset values within the same cycle, without a clock edge.
